// File: rtl/mem_view_sequencer.sv
// Read sequencer for the memory viewer: issues one req/ack read at a time to REG/RAM/ROM,
// captures the returned word with its display address and holds it for a dwell period.
module mem_view_sequencer #(
  parameter int DWELL   = 50_000_000,
  parameter int TIMEOUT = 1024
) (
  input  logic        CLOCK,
  input  logic        RESET_N,
  input  logic        MODE,
  input  logic [1:0]  MAN_SEL,
  input  logic [4:0]  MAN_ADDR,
  output logic        RD_REQ,
  output logic [1:0]  RD_SEL,
  output logic [4:0]  RD_ADDR,
  input  logic        RD_ACK,
  input  logic [31:0] RD_DATA,
  output logic [31:0] DATA,
  output logic [31:0] MEM,
  output logic [1:0]  SEL_OUT,
  output logic        ERR
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DWELL} state_t;

  localparam logic [31:0] DWELL_LAST   = 32'(DWELL - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_nextState;
  logic [31:0] r_cnt;
  logic [1:0]  r_ptrSrc;
  logic [4:0]  r_ptrIdx;

  logic        w_enterIssue;
  logic        w_capture;
  logic        w_timeout;
  logic        w_advance;
  logic [1:0]  w_advSrc;
  logic [4:0]  w_advIdx;
  logic [1:0]  w_scanSrc;
  logic [4:0]  w_scanIdx;
  logic [1:0]  w_loadSel;
  logic [4:0]  w_loadAddr;
  logic [31:0] w_capMem;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // An ack takes priority over a timeout expiring on the same edge.
  always_comb begin
    w_nextState  = r_state;
    w_enterIssue = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    w_advance    = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_nextState  = S_ISSUE;
        w_enterIssue = 1'b1;
      end
      S_ISSUE: begin
        if (RD_ACK) begin
          w_capture   = 1'b1;
          w_nextState = S_DWELL;
        end else if (r_cnt == TIMEOUT_LAST) begin
          w_timeout   = 1'b1;
          w_nextState = S_DWELL;
        end
      end
      S_DWELL: begin
        if (r_cnt == DWELL_LAST) begin
          w_nextState  = S_ISSUE;
          w_enterIssue = 1'b1;
          w_advance    = MODE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_comb begin
    w_advIdx = r_ptrIdx + 5'd1;
    w_advSrc = r_ptrSrc;
    if (r_ptrIdx == 5'd31) begin
      w_advSrc = (r_ptrSrc == 2'd2) ? 2'd0 : r_ptrSrc + 2'd1;
    end
    w_scanSrc  = w_advance ? w_advSrc : r_ptrSrc;
    w_scanIdx  = w_advance ? w_advIdx : r_ptrIdx;
    w_loadSel  = MODE ? w_scanSrc : ((MAN_SEL == 2'd3) ? 2'd0 : MAN_SEL);
    w_loadAddr = MODE ? w_scanIdx : MAN_ADDR;
    w_capMem   = (RD_SEL == 2'd0) ? {27'd0, RD_ADDR} : {25'd0, RD_ADDR, 2'b00};
  end

  // The counter restarts on every state change, so it measures time spent in the current state.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_cnt    <= '0;
      r_ptrSrc <= '0;
      r_ptrIdx <= '0;
      RD_REQ   <= 1'b0;
      RD_SEL   <= '0;
      RD_ADDR  <= '0;
    end else begin
      r_cnt <= (w_nextState != r_state) ? 32'd0 : r_cnt + 32'd1;
      if (w_advance) begin
        r_ptrSrc <= w_advSrc;
        r_ptrIdx <= w_advIdx;
      end
      if (w_enterIssue) begin
        RD_REQ  <= 1'b1;
        RD_SEL  <= w_loadSel;
        RD_ADDR <= w_loadAddr;
      end else if (w_capture || w_timeout) begin
        RD_REQ <= 1'b0;
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      DATA    <= '0;
      MEM     <= '0;
      SEL_OUT <= '0;
      ERR     <= 1'b0;
    end else if (w_capture || w_timeout) begin
      DATA    <= w_capture ? RD_DATA : 32'hDEADBEEF;
      MEM     <= w_capMem;
      SEL_OUT <= RD_SEL;
      ERR     <= w_timeout;
    end
  end

endmodule

// File: tb/tb_mem_view_sequencer.sv
// Self-checking bench for mem_view_sequencer: directed steps with randomized data, delays and
// manual addresses, checked against a reference model of the read/capture rules.
module tb_mem_view_sequencer;

  localparam int DWELL   = 4;
  localparam int TIMEOUT = 8;

  logic        CLOCK    = 1'b0;
  logic        RESET_N  = 1'b0;
  logic        MODE     = 1'b1;
  logic [1:0]  MAN_SEL  = 2'd0;
  logic [4:0]  MAN_ADDR = 5'd0;
  logic        RD_ACK   = 1'b0;
  logic [31:0] RD_DATA  = 32'd0;
  logic        RD_REQ;
  logic [1:0]  RD_SEL;
  logic [4:0]  RD_ADDR;
  logic [31:0] DATA;
  logic [31:0] MEM;
  logic [1:0]  SEL_OUT;
  logic        ERR;

  int checks = 0;
  int errors = 0;

  logic [31:0] expData;
  logic [31:0] expMem;
  logic [1:0]  expSel;
  logic        expErr;

  mem_view_sequencer #(.DWELL(DWELL), .TIMEOUT(TIMEOUT)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .MODE(MODE), .MAN_SEL(MAN_SEL), .MAN_ADDR(MAN_ADDR),
    .RD_REQ(RD_REQ), .RD_SEL(RD_SEL), .RD_ADDR(RD_ADDR), .RD_ACK(RD_ACK), .RD_DATA(RD_DATA),
    .DATA(DATA), .MEM(MEM), .SEL_OUT(SEL_OUT), .ERR(ERR)
  );

  always #5 CLOCK = ~CLOCK;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 200000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Display address rule: word index for REG, byte address (4*index) for RAM/ROM.
  task automatic setExpect(input int sel, input int addr, input logic [31:0] data, input logic err);
    expSel  = 2'(sel);
    expMem  = (sel == 0) ? 32'(addr) : 32'(addr * 4);
    expData = data;
    expErr  = err;
  endtask

  task automatic checkCapture(input string tag);
    checkOutput({tag, ".DATA"}, DATA, expData);
    checkOutput({tag, ".MEM"}, MEM, expMem);
    checkOutput({tag, ".SEL_OUT"}, 32'(SEL_OUT), 32'(expSel));
    checkOutput({tag, ".ERR"}, 32'(ERR), 32'(expErr));
  endtask

  task automatic checkRequest(input string tag, input int sel, input int addr);
    checkOutput({tag, ".RD_SEL"}, 32'(RD_SEL), 32'(sel));
    checkOutput({tag, ".RD_ADDR"}, 32'(RD_ADDR), 32'(addr));
  endtask

  task automatic waitReq(input string tag);
    int n = 0;
    while (RD_REQ !== 1'b1 && n < 20) begin
      @(negedge CLOCK);
      n++;
    end
    checkOutput({tag, ".reqArrive"}, 32'(RD_REQ), 32'd1);
  endtask

  // Called on the negedge right after RD_REQ rose; ack is sampled on the delay-th ISSUE edge.
  task automatic applyStimulus(input int delay, input logic [31:0] data);
    repeat (delay - 1) @(negedge CLOCK);
    RD_ACK  = 1'b1;
    RD_DATA = data;
    @(negedge CLOCK);
    RD_ACK  = 1'b0;
    RD_DATA = $urandom;
  endtask

  task automatic measureGap(output int gap);
    gap = 0;
    do begin
      @(negedge CLOCK);
      gap++;
    end while (RD_REQ !== 1'b1 && gap < 20);
  endtask

  function automatic int manSel(input logic [1:0] s);
    return (s == 2'd3) ? 0 : int'(s);
  endfunction

  initial begin
    int gap;
    int highCount;
    int sel;
    int addr;
    int delay;
    logic [31:0] data;

    $display("[TB] reset and release");
    repeat (3) @(negedge CLOCK);
    setExpect(0, 0, 32'd0, 1'b0);
    checkCapture("reset");
    checkOutput("reset.RD_REQ", 32'(RD_REQ), 32'd0);
    checkRequest("reset", 0, 0);
    RESET_N = 1'b1;
    #1 checkOutput("release.noReqYet", 32'(RD_REQ), 32'd0);
    @(negedge CLOCK);
    checkOutput("release.RD_REQ", 32'(RD_REQ), 32'd1);
    checkRequest("release", 0, 0);

    // Manual inputs changed during ISSUE must only affect the following read.
    MODE     = 1'b0;
    MAN_SEL  = 2'd1;
    MAN_ADDR = 5'd5;
    data = $urandom;
    applyStimulus(1, data);
    setExpect(0, 0, data, 1'b0);
    checkCapture("firstRead");
    measureGap(gap);
    checkOutput("firstRead.gap", 32'(gap), 32'(DWELL));
    checkRequest("manual", 1, 5);

    $display("[TB] manual read");
    applyStimulus(2, 32'h12345678);
    setExpect(1, 5, 32'h12345678, 1'b0);
    checkCapture("manual");
    checkOutput("manual.MEM20", MEM, 32'd20);
    measureGap(gap);
    checkOutput("manual.gap", 32'(gap), 32'(DWELL));
    checkRequest("manualRepeat", 1, 5);

    $display("[TB] stray ack during dwell");
    data = $urandom;
    applyStimulus(1, data);
    setExpect(1, 5, data, 1'b0);
    checkCapture("preStray");
    RD_ACK  = 1'b1;
    RD_DATA = 32'hCAFEF00D;
    @(negedge CLOCK);
    RD_ACK  = 1'b0;
    checkCapture("stray");
    checkOutput("stray.RD_REQ", 32'(RD_REQ), 32'd0);

    $display("[TB] manual select 3");
    MAN_SEL  = 2'd3;
    MAN_ADDR = 5'd7;
    waitReq("sel3");
    checkRequest("sel3", 0, 7);
    data = $urandom;
    applyStimulus(2, data);
    setExpect(0, 7, data, 1'b0);
    checkCapture("sel3");

    $display("[TB] random manual reads");
    for (int i = 0; i < 6; i++) begin
      MAN_SEL  = 2'($urandom_range(0, 3));
      MAN_ADDR = 5'($urandom);
      sel  = manSel(MAN_SEL);
      addr = int'(MAN_ADDR);
      waitReq("rand");
      checkRequest("rand", sel, addr);
      data  = $urandom;
      delay = $urandom_range(1, TIMEOUT);
      applyStimulus(delay, data);
      setExpect(sel, addr, data, 1'b0);
      checkCapture("rand");
    end

    $display("[TB] timeout");
    MAN_SEL  = 2'd2;
    MAN_ADDR = 5'd9;
    waitReq("timeout");
    checkRequest("timeout", 2, 9);
    highCount = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK);
      if (RD_REQ !== 1'b1) break;
      highCount++;
    end
    checkOutput("timeout.reqHigh", 32'(highCount), 32'(TIMEOUT));
    setExpect(2, 9, 32'hDEADBEEF, 1'b1);
    checkCapture("timeout");

    waitReq("clearErr");
    data = $urandom;
    applyStimulus(3, data);
    setExpect(2, 9, data, 1'b0);
    checkCapture("clearErr");

    $display("[TB] ack on final timeout cycle");
    waitReq("race");
    data = $urandom;
    applyStimulus(TIMEOUT, data);
    setExpect(2, 9, data, 1'b0);
    checkCapture("race");

    $display("[TB] async reset mid-issue");
    waitReq("midReset");
    #2 RESET_N = 1'b0;
    #1 checkOutput("midReset.RD_REQ", 32'(RD_REQ), 32'd0);
    setExpect(0, 0, 32'd0, 1'b0);
    checkCapture("midReset");
    checkRequest("midReset", 0, 0);
    @(negedge CLOCK);
    @(negedge CLOCK);
    MODE    = 1'b1;
    RESET_N = 1'b1;

    $display("[TB] auto scan");
    for (int i = 0; i <= 96; i++) begin
      int p;
      p = i % 96;
      waitReq("scan");
      checkRequest("scan", p / 32, p % 32);
      data = $urandom;
      applyStimulus(1, data);
      setExpect(p / 32, p % 32, data, 1'b0);
      checkCapture("scan");
      if (p == 63) checkOutput("scan.ram31MEM", MEM, 32'd124);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_view_sequencer.md
# mem_view_sequencer

Read sequencer for the memory viewer datapath. It selects which source (REG, RAM or ROM) and which word index is shown, and issues one read at a time to that source with a req/ack handshake. It captures the returned word and its display address, then holds them for a fixed dwell period before the next read. In auto mode it scans every word of every source in turn; in manual mode it keeps refreshing the word chosen by the board switches.

## Interface
Parameters:
- DWELL, 50_000_000: cycles each captured word is held before the next read is issued (≥2).
- TIMEOUT, 1024: cycles to wait for RD_ACK before abandoning a read (≥2).

Ports:
- CLOCK  in  1  system clock, all state on rising edge.
- RESET_N  in  1  asynchronous active-low reset.
- MODE  in  1  0 = manual, 1 = auto scan.
- MAN_SEL  in  2  manual source: 0 REG, 1 RAM, 2 ROM, 3 treated as 0.
- MAN_ADDR  in  5  manual word index.
- RD_REQ  out  1  read request, held until ack or timeout.
- RD_SEL  out  2  source of current read, stable while RD_REQ=1.
- RD_ADDR  out  5  word index of current read, stable while RD_REQ=1.
- RD_ACK  in  1  one-cycle read completion from selected source.
- RD_DATA  in  32  read data, valid when RD_ACK=1.
- DATA  out  32  captured word for display.
- MEM  out  32  display address of captured word: index for REG, 4*index for RAM/ROM, zero-extended.
- SEL_OUT  out  2  source of captured word.
- ERR  out  1  high if the last read timed out.

## Operation
- States: IDLE, ISSUE, DWELL.
- IDLE: entered on reset. Moves to ISSUE on the first clock edge after RESET_N deasserts.
- Entry to ISSUE loads RD_SEL/RD_ADDR:
  - MODE=0: from MAN_SEL (3→0) and MAN_ADDR.
  - MODE=1: from the scan pointer.
- ISSUE drives RD_REQ=1. While in ISSUE, an edge with RD_ACK=1 does all of the following, then moves to DWELL:
  - DATA←RD_DATA.
  - SEL_OUT←RD_SEL.
  - MEM←RD_SEL==0 ? RD_ADDR : RD_ADDR<<2.
  - ERR←0.
- Timeout: if no ack arrives within TIMEOUT cycles in ISSUE, the block does all of the following, then moves to DWELL:
  - DATA←32'hDEADBEEF.
  - SEL_OUT and MEM updated as for an ack.
  - ERR←1.
- DWELL: a counter runs DWELL cycles, then the block returns to ISSUE.
- Scan pointer {src, idx} reset value is {0,0}.
  - Advances only when leaving DWELL in MODE=1.
  - idx increments 0→31. On wrap to 0, src advances 0→1→2→0.
  - In MODE=0 the pointer holds.
- MODE, MAN_SEL and MAN_ADDR are sampled only on ISSUE entry. Changes during ISSUE/DWELL take effect on the next read.
- RD_ACK outside ISSUE is ignored; no output changes.
- RD_ACK on the same edge the timeout expires: the ack wins (real data, ERR=0).

## Timing
- Reset (async, immediate) sets:
  - state=IDLE, counters=0, pointer={0,0}.
  - RD_REQ=0, RD_SEL=0, RD_ADDR=0.
  - DATA=0, MEM=0, SEL_OUT=0, ERR=0.
- Reset asserted mid-read drops RD_REQ immediately. No capture occurs.
- RD_REQ is registered:
  - It rises one cycle after reset release (IDLE→ISSUE).
  - It falls on the cycle after the ack or timeout edge.
- Capture latency: DATA/MEM/SEL_OUT/ERR update on the same edge that samples RD_ACK=1, visible the following cycle.
- Ack-edge to next RD_REQ rise: exactly DWELL cycles.
- Timeout: RD_REQ high for exactly TIMEOUT cycles, then low.
- An ack in the first ISSUE cycle is legal. Minimum RD_REQ pulse is 1 cycle.

## Test plan
Bench settings: DWELL=4, TIMEOUT=8.

- Reset/release:
  - Stimulus: hold RESET_N=0 for 3 cycles, then release.
  - Required: all outputs 0 during reset; RD_REQ=1 one cycle after release, with RD_SEL=0, RD_ADDR=0.
- Manual read:
  - Stimulus: MODE=0, MAN_SEL=1, MAN_ADDR=5; ack after 2 cycles with RD_DATA=32'h12345678.
  - Required: DATA=32'h12345678, MEM=20, SEL_OUT=1, ERR=0. Next RD_REQ 4 cycles after the ack, same address.
- Auto scan wrap:
  - Stimulus: MODE=1; ack every request immediately.
  - Required:
    - RD_ADDR sequence 0..31 with RD_SEL=0, then 0..31 with RD_SEL=1, then RD_SEL=2, then back to RD_SEL=0, idx 0.
    - MEM for RAM idx 31 = 124.
- Timeout:
  - Stimulus: no ack.
  - Required: RD_REQ high 8 cycles, then DATA=32'hDEADBEEF, ERR=1. The next acked read clears ERR.
- Ack/timeout race and stray ack:
  - Stimulus: ack on the 8th ISSUE cycle; separately, an ack during DWELL.
  - Required: first case captures real data with ERR=0; second case leaves outputs unchanged.
- Async reset mid-ISSUE and MAN_SEL=3:
  - Stimulus: assert reset while RD_REQ=1; separately, issue a manual read with MAN_SEL=3, MAN_ADDR=7.
  - Required:
    - First case: RD_REQ drops without a clock edge.
    - Second case: RD_SEL=0, and after ack MEM=7.
